register_file: RTL

32-entry, 32-bit integer register file for the single-cycle RV32I datapath, sitting directly upstream of the ALU. Provides two combinational read ports (RD1 drives SrcA; RD2 drives the SrcB mux) and one synchronous write port from the writeback mux. x0 is hardwired to zero. After every reset a built-in clear sequencer zeroes x1..x31 one register per cycle and holds Busy high until done.

---
 rtl/register_file.sv | 48 ++++
 1 files changed

// File: rtl/register_file.sv
// register_file: 32x32 RV32I register file, two async read ports, one write port, post-reset clear sequencer.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic [AW-1:0]    A3,
  input  logic             WE3,
  input  logic [WIDTH-1:0] WD3,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic             Busy
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_en, fwd1, fwd2;
  assign Busy  = state_q == CLEAR;
  assign wr_en = !Busy && WE3 && A3 != '0;
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_en && A1 == A3;
  assign fwd2 = wr_en && A2 == A3;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  always_comb begin
    state_d   = reset ? CLEAR : (Busy && clr_idx_q == AW'(DEPTH - 1)) ? RUN : state_q;
    clr_idx_d = reset ? AW'(1) : Busy ? clr_idx_q + AW'(1) : clr_idx_q;
    RD1       = (Busy || A1 == '0) ? '0 : fwd1 ? WD3 : regs_q[A1];
    RD2       = (Busy || A2 == '0) ? '0 : fwd2 ? WD3 : regs_q[A2];
  end
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    if (!reset && Busy)
      regs_q[clr_idx_q] <= '0;
    else if (!reset && wr_en)
      regs_q[A3] <= WD3;
  end
endmodule
